// File: rtl/sreg_pkg.sv
// Shared types and the single-position shift function used by both the
// single-step and burst paths of shift_register_universal.
package sreg_pkg;

  localparam int SREG_MAX_W = 64;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    ROR  = 3'b011,
    ROL  = 3'b100,
    ASR  = 3'b101
  } sreg_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sreg_state_t;

  // Operates on a zero-extended word; msb is the index of the caller's top bit.
  // Bits above msb are don't-care and get truncated by the caller.
  function automatic logic [SREG_MAX_W-1:0] sreg_step(
    input logic [SREG_MAX_W-1:0] data,
    input logic [2:0]            mode,
    input logic [5:0]            msb,
    input logic                  in_l,
    input logic                  in_r
  );
    logic [SREG_MAX_W-1:0] r;
    r = data;
    case (mode)
      SHR: begin r = data >> 1; r[msb] = in_l;      end
      SHL: begin r = data << 1; r[0]   = in_r;      end
      ROR: begin r = data >> 1; r[msb] = data[0];   end
      ROL: begin r = data << 1; r[0]   = data[msb]; end
      ASR: begin r = data >> 1; r[msb] = data[msb]; end
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sreg_burst_ctrl.sv
// Burst sequencer: latches mode/count on start, issues one step per edge
// while busy, pulses done on completion; abort (parallel load) cancels silently.
module sreg_burst_ctrl
  import sreg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  input  logic [2:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             step,
  output sreg_mode_t       mode_lat
);

  sreg_state_t      state;
  logic [CNT_W-1:0] remaining;

  assign busy = (state == BURST);
  assign step = busy && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
      mode_lat  <= HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            mode_lat <= sreg_mode_t'(mode);
            if (count != '0) begin
              state     <= BURST;
              remaining <= count;
            end else begin
              done <= 1'b1;
            end
          end
        end
        BURST: begin
          if (abort) begin
            state     <= IDLE;
            remaining <= '0;
          end else begin
            // remaining counts the shifts still owed, including this edge's
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register with parallel load, single-step and burst shifts.
// Define SREG_PARITY_EN to add the registered Parity output.
module shift_register_universal
  import sreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic [2:0]       Mode,
  input  logic             Shift_In_L,
  input  logic             Shift_In_R,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Shift_Out_R,
  output logic             Shift_Out_L,
  output logic [WIDTH-1:0] Data_Out
`ifdef SREG_PARITY_EN
  ,
  output logic             Parity
`endif
);

  localparam logic [5:0] MSB = 6'(WIDTH - 1);

  logic                  step;
  sreg_mode_t            mode_lat;
  logic [WIDTH-1:0]      next_data;
  logic [SREG_MAX_W-1:0] burst_word;
  logic [SREG_MAX_W-1:0] single_word;

  sreg_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk      (Clk),
    .rst      (Reset),
    .start    (Start),
    .abort    (Load),
    .count    (Count),
    .mode     (Mode),
    .busy     (Busy),
    .done     (Done),
    .step     (step),
    .mode_lat (mode_lat)
  );

  assign burst_word  = sreg_step(SREG_MAX_W'(Data_Out), mode_lat, MSB, Shift_In_L, Shift_In_R);
  assign single_word = sreg_step(SREG_MAX_W'(Data_Out), Mode, MSB, Shift_In_L, Shift_In_R);

  // Start in idle suppresses the single step even when Count is zero
  always_comb begin
    next_data = Data_Out;
    if (Load)
      next_data = D;
    else if (step)
      next_data = burst_word[WIDTH-1:0];
    else if (!Busy && !Start && Shift_En)
      next_data = single_word[WIDTH-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Data_Out <= '0;
    else       Data_Out <= next_data;
  end

`ifdef SREG_PARITY_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Parity <= 1'b0;
    else       Parity <= ^next_data;
  end
`endif

  assign Shift_Out_R = Data_Out[0];
  assign Shift_Out_L = Data_Out[WIDTH-1];

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed and randomized bench for shift_register_universal (WIDTH=8, CNT_W=4)
// against an arithmetic reference model.
module tb_shift_register_universal;

  logic       Clk = 1'b0;
  logic       Reset, Load, Shift_En, Shift_In_L, Shift_In_R, Start;
  logic [7:0] D;
  logic [2:0] Mode;
  logic [3:0] Count;
  logic       Busy, Done, Shift_Out_R, Shift_Out_L;
  logic [7:0] Data_Out;
`ifdef SREG_PARITY_EN
  logic       Parity;
`endif

  int checks = 0;
  int errors = 0;

  int m_data, m_rem, m_mode;
  bit m_busy, m_done;

  shift_register_universal #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .D(D), .Shift_En(Shift_En), .Mode(Mode),
    .Shift_In_L(Shift_In_L), .Shift_In_R(Shift_In_R), .Start(Start), .Count(Count),
    .Busy(Busy), .Done(Done), .Shift_Out_R(Shift_Out_R), .Shift_Out_L(Shift_Out_L),
    .Data_Out(Data_Out)
`ifdef SREG_PARITY_EN
    , .Parity(Parity)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic int mstep(int d, int mode, int il, int ir);
    case (mode)
      1: return (d >> 1) | (il << 7);
      2: return ((d << 1) | ir) & 255;
      3: return (d >> 1) | ((d & 1) << 7);
      4: return ((d << 1) & 255) | (d >> 7);
      5: return (d >> 1) | (d & 128);
      default: return d;
    endcase
  endfunction

  function automatic int parity8(int d);
    int p = 0;
    for (int i = 0; i < 8; i++) p ^= (d >> i) & 1;
    return p;
  endfunction

  task automatic model_reset();
    m_data = 0; m_rem = 0; m_mode = 0; m_busy = 0; m_done = 0;
  endtask

  // Next state from the inputs about to be sampled.
  task automatic model_edge();
    m_done = 0;
    if (Load) begin
      m_data = int'(D); m_busy = 0; m_rem = 0;
    end else if (m_busy) begin
      m_data = mstep(m_data, m_mode, int'(Shift_In_L), int'(Shift_In_R));
      m_rem--;
      if (m_rem == 0) begin m_busy = 0; m_done = 1; end
    end else if (Start) begin
      m_mode = int'(Mode);
      if (Count != 0) begin m_busy = 1; m_rem = int'(Count); end
      else m_done = 1;
    end else if (Shift_En) begin
      m_data = mstep(m_data, int'(Mode), int'(Shift_In_L), int'(Shift_In_R));
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "_data"}, 32'(Data_Out), 32'(m_data));
    check({tag, "_busy"}, 32'(Busy), 32'(m_busy));
    check({tag, "_done"}, 32'(Done), 32'(m_done));
    check({tag, "_sor"}, 32'(Shift_Out_R), 32'(m_data & 1));
    check({tag, "_sol"}, 32'(Shift_Out_L), 32'((m_data >> 7) & 1));
`ifdef SREG_PARITY_EN
    check({tag, "_par"}, 32'(Parity), 32'(parity8(m_data)));
`endif
  endtask

  task automatic cycle(string tag);
    model_edge();
    @(posedge Clk);
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    Load = 0; D = '0; Shift_En = 0; Mode = '0; Shift_In_L = 0; Shift_In_R = 0;
    Start = 0; Count = '0;
  endtask

  initial begin
    int bh, dn;
    idle_inputs();
    Reset = 1;
    model_reset();
    @(negedge Clk);
    check_all("reset");
    Reset = 0;

    // Async reset mid-burst
    Load = 1; D = 8'hA5; cycle("t1_load"); Load = 0;
    Start = 1; Mode = 3'd4; Count = 4'd5; cycle("t1_start"); Start = 0;
    cycle("t1_burst");
    check("t1_busy_before", 32'(Busy), 32'd1);
    @(posedge Clk); #2 Reset = 1; #1;
    check("t1_rst_data", 32'(Data_Out), 32'h00);
    check("t1_rst_busy", 32'(Busy), 32'd0);
    check("t1_rst_done", 32'(Done), 32'd0);
    model_reset();
    @(negedge Clk); Reset = 0;
    cycle("t1_after");

    // Single-step SHR
    Load = 1; D = 8'h96; cycle("t2_load"); Load = 0;
    check("t2_sor_before", 32'(Shift_Out_R), 32'd0);
    Shift_En = 1; Mode = 3'd1; Shift_In_L = 1; cycle("t2_shr"); Shift_En = 0; Shift_In_L = 0;
    check("t2_val", 32'(Data_Out), 32'hCB);

    // Burst ROL x3
    Load = 1; D = 8'h81; cycle("t3_load"); Load = 0;
    Start = 1; Mode = 3'd4; Count = 4'd3; cycle("t3_start"); Start = 0;
    bh = int'(Busy); dn = int'(Done);
    repeat (4) begin cycle("t3_run"); bh += int'(Busy); dn += int'(Done); end
    check("t3_busy_cycles", 32'(bh), 32'd3);
    check("t3_done_pulses", 32'(dn), 32'd1);
    check("t3_val", 32'(Data_Out), 32'h0C);

    // Burst ASR x7 with Mode churn
    Load = 1; D = 8'h80; cycle("t4_load"); Load = 0;
    Start = 1; Mode = 3'd5; Count = 4'd7; cycle("t4_start"); Start = 0;
    repeat (3) begin Mode = 3'($urandom_range(0, 7)); cycle("t4_toggle"); end
    repeat (6) cycle("t4_run");
    check("t4_val", 32'(Data_Out), 32'hFF);

    // Load aborts burst
    Load = 1; D = 8'hFF; cycle("t5_load"); Load = 0;
    Start = 1; Mode = 3'd2; Count = 4'd5; Shift_In_R = 0; cycle("t5_start"); Start = 0;
    cycle("t5_b1");
    Load = 1; D = 8'h3C; cycle("t5_abort"); Load = 0;
    check("t5_val", 32'(Data_Out), 32'h3C);
    check("t5_busy", 32'(Busy), 32'd0);
    dn = 0;
    repeat (6) begin cycle("t5_after"); dn += int'(Done); end
    check("t5_no_done", 32'(dn), 32'd0);

    // Count=0 and Start while busy
    Start = 1; Shift_En = 1; Mode = 3'd1; Count = 4'd0; cycle("t6_zero"); Start = 0; Shift_En = 0;
    check("t6_zero_done", 32'(Done), 32'd1);
    check("t6_zero_data", 32'(Data_Out), 32'h3C);
    Start = 1; Mode = 3'd3; Count = 4'd3; cycle("t6_start");
    Count = 4'd5; dn = 0;
    repeat (2) begin cycle("t6_restart"); dn += int'(Done); end
    Start = 0;
    repeat (6) begin cycle("t6_run"); dn += int'(Done); end
    check("t6_single_done", 32'(dn), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      Load       = ($urandom_range(0, 9) == 0);
      D          = 8'($urandom);
      Start      = ($urandom_range(0, 5) == 0);
      Shift_En   = 1'($urandom);
      Mode       = 3'($urandom);
      Count      = 4'($urandom);
      Shift_In_L = 1'($urandom);
      Shift_In_R = 1'($urandom);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
